// File: rtl/fir_out_requant.sv
// FIR output requantiser: decimate, round half-up, saturate, then buffer in a
// first-word-fall-through FIFO with sticky overflow/drop flags.
module fir_out_requant #(
    parameter int G_I_W   = 23,
    parameter int G_O_W   = 12,
    parameter int G_SHIFT = 8,
    parameter int G_DECIM = 4,
    parameter int G_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [G_I_W-1:0] i_result,
    input  logic             i_clr,
    output logic [G_O_W-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_ovf,
    output logic             o_drop
);

    localparam int PH_W = (G_DECIM > 1) ? $clog2(G_DECIM) : 1;
    localparam int A_W  = $clog2(G_DEPTH);
    localparam int C_W  = A_W + 1;

    localparam logic [PH_W-1:0]     PH_LAST = PH_W'(G_DECIM - 1);
    localparam logic signed [G_I_W:0] RND   = $signed({{G_I_W{1'b0}}, 1'b1} << (G_SHIFT - 1));
    localparam logic signed [G_I_W:0] SAT_MAX =
        $signed({{(G_I_W - G_O_W + 2){1'b0}}, {(G_O_W - 1){1'b1}}});
    localparam logic signed [G_I_W:0] SAT_MIN =
        $signed({{(G_I_W - G_O_W + 2){1'b1}}, {(G_O_W - 1){1'b0}}});

    logic [PH_W-1:0]        phase;
    logic                   take;
    logic signed [G_I_W:0]  ext;
    logic signed [G_I_W:0]  rounded;
    logic signed [G_I_W:0]  s1_val;
    logic                   s1_valid;
    logic [G_O_W-1:0]       sat;
    logic                   clamp;

    logic [G_O_W-1:0]       mem [G_DEPTH];
    logic [A_W-1:0]         wr_ptr;
    logic [A_W-1:0]         rd_ptr;
    logic [C_W-1:0]         count;
    logic                   full;
    logic                   pop;
    logic                   wr;
    logic                   drop_evt;
    logic                   ovf_evt;

    assign take    = i_en && (phase == '0);
    assign ext     = $signed({i_result[G_I_W-1], i_result}) + RND;
    assign rounded = ext >>> G_SHIFT;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase <= '0;
        end else if (i_en) begin
            phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_val   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= take;
            if (take) begin
                s1_val <= rounded;
            end
        end
    end

    always_comb begin
        sat   = s1_val[G_O_W-1:0];
        clamp = 1'b0;
        if (s1_val > SAT_MAX) begin
            sat   = SAT_MAX[G_O_W-1:0];
            clamp = 1'b1;
        end else if (s1_val < SAT_MIN) begin
            sat   = SAT_MIN[G_O_W-1:0];
            clamp = 1'b1;
        end
    end

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign full     = (count == C_W'(G_DEPTH));
    assign o_valid  = (count != '0);
    assign pop      = o_valid && i_ready;
    assign wr       = s1_valid && (!full || pop);
    assign drop_evt = s1_valid && full && !pop;
    assign ovf_evt  = s1_valid && clamp;
    assign o_data   = o_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
        if (wr) begin
            mem[wr_ptr] <= sat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + A_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + A_W'(1);
            end
            if (wr && !pop) begin
                count <= count + C_W'(1);
            end else if (!wr && pop) begin
                count <= count - C_W'(1);
            end
        end
    end

    // Set events take priority over a same-edge clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf  <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            if (ovf_evt) begin
                o_ovf <= 1'b1;
            end else if (i_clr) begin
                o_ovf <= 1'b0;
            end
            if (drop_evt) begin
                o_drop <= 1'b1;
            end else if (i_clr) begin
                o_drop <= 1'b0;
            end
        end
    end

endmodule
